if_id_skid: RTL and testbench

- Pipeline boundary between instruction fetch and decode.
- Captures the fetch stage's aligned pc/instruction pair into the ID register.
- Drives the fetch stage's hold input from a flop, so the decode stall path never reaches the instruction-memory address mux combinationally.
- The one-cycle hold latency is absorbed by a 2-entry skid FIFO. Jumps kill all wrong-path instructions.

---
 rtl/if_id_skid_pkg.sv | 6 +
 rtl/skid_fifo2.sv | 42 ++++
 rtl/if_id_skid.sv | 88 ++++++++
 tb/tb_if_id_skid.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_id_skid_pkg.sv
// Shared fetch/decode constants: datapath width, NOP encoding, catch depth.
package if_id_skid_pkg;
  localparam int          XLEN_DFLT      = 32;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;
  localparam int          InstCatchDepth = 2;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO; 1-bit wrapping pointers, occupancy tracked by count.
module skid_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/if_id_skid.sv
// IF/ID boundary: registered fetch hold, 2-entry skid buffer absorbs the hold latency.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int XLEN       = XLEN_DFLT,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_pc,
  input  logic [XLEN-1:0] IF_inst,
  input  logic            jmp_vld,
  input  logic            id_stall,
  output logic            IF_hold,
  output logic            ID_vld,
  output logic [XLEN-1:0] ID_pc,
  output logic [XLEN-1:0] ID_inst
);
  generate
    if (SKID_DEPTH != 2) begin : g_bad_depth
      $error("if_id_skid: SKID_DEPTH must be 2");
    end
  endgenerate

  logic              hold_d, flush_d;
  logic              in_new, ld, take_head, take_in, push, pop;
  logic [1:0]        count, count_next;
  logic              full, empty;
  logic [2*XLEN-1:0] head;

  skid_fifo2 #(.W(2*XLEN)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (jmp_vld),
    .push (push),
    .pop  (pop),
    .din  ({IF_pc, IF_inst}),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // A pair shown while hold was already registered is a repeat of last cycle's pair.
  assign in_new    = flush_d | ~hold_d;
  assign ld        = ~ID_vld | ~id_stall;
  assign take_head = ~jmp_vld & ld & ~empty;
  assign take_in   = ~jmp_vld & ld & empty & in_new;
  assign pop       = take_head;
  assign push      = ~jmp_vld & in_new & ~take_in;

  always_comb begin
    count_next = count + 2'(push) - 2'(pop);
    if (jmp_vld) count_next = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_d  <= 1'b0;
      flush_d <= 1'b0;
      IF_hold <= 1'b0;
      ID_vld  <= 1'b0;
      ID_pc   <= '0;
      ID_inst <= XLEN'(NOP_INST);
    end else begin
      hold_d  <= IF_hold;
      flush_d <= jmp_vld;
      IF_hold <= (count_next != 2'd0);
      if (jmp_vld) begin
        ID_vld <= 1'b0;
      end else if (ld) begin
        if (take_head) begin
          ID_vld           <= 1'b1;
          {ID_pc, ID_inst} <= head;
        end else if (take_in) begin
          ID_vld  <= 1'b1;
          ID_pc   <= IF_pc;
          ID_inst <= IF_inst;
        end else begin
          ID_vld <= 1'b0;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("if_id_skid: push into full skid FIFO");
endmodule

// File: tb/tb_if_id_skid.sv
// Directed table-driven bench for if_id_skid with a behavioural fetch stage.
module tb_if_id_skid;
  localparam logic [31:0] KEY = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IF_pc, IF_inst;
  logic        jmp_vld = 1'b0;
  logic [31:0] jmp_addr = '0;
  logic        id_stall = 1'b0;
  logic        IF_hold, ID_vld;
  logic [31:0] ID_pc, ID_inst;

  int checks = 0;
  int errors = 0;

  if_id_skid dut (
    .clk     (clk),
    .rst     (rst),
    .IF_pc   (IF_pc),
    .IF_inst (IF_inst),
    .jmp_vld (jmp_vld),
    .id_stall(id_stall),
    .IF_hold (IF_hold),
    .ID_vld  (ID_vld),
    .ID_pc   (ID_pc),
    .ID_inst (ID_inst)
  );

  always #5 clk = ~clk;

  // Fetch: pc register honours hold, redirects on jump; ROM data keyed by pc.
  logic [31:0] pc_f;
  always @(posedge clk or posedge rst) begin
    if (rst) pc_f <= '0;
    else if (jmp_vld) pc_f <= jmp_addr;
    else if (!IF_hold) pc_f <= pc_f + 32'd4;
  end
  assign IF_pc   = pc_f;
  assign IF_inst = pc_f ^ KEY;

  typedef struct {
    logic        stall;
    logic        jmp;
    logic [31:0] jaddr;
    logic        vld;
    logic [31:0] pc;
    logic        hold;
  } vec_t;

  vec_t vecs[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // expected values are after the edge of the row's cycle
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h18, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h00, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 32'hC0, 1'b0, 32'h00, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC0, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC4, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC8, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0};
    vecs[28] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hCC, 1'b0};
    vecs[29] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hCC, 1'b1};
    vecs[30] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hCC, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  {31'b0, ID_vld},  32'd0);
    chk("rst_hold", {31'b0, IF_hold}, 32'd0);
    chk("rst_pc",   ID_pc,            32'h0);
    chk("rst_inst", ID_inst,          NOP);
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      id_stall = vecs[i].stall;
      jmp_vld  = vecs[i].jmp;
      jmp_addr = vecs[i].jaddr;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_vld", i),  {31'b0, ID_vld},  {31'b0, vecs[i].vld});
      chk($sformatf("r%0d_hold", i), {31'b0, IF_hold}, {31'b0, vecs[i].hold});
      if (vecs[i].vld) begin
        chk($sformatf("r%0d_pc", i),   ID_pc,   vecs[i].pc);
        chk($sformatf("r%0d_inst", i), ID_inst, vecs[i].pc ^ KEY);
      end
    end

    // asynchronous reset with two entries pending and hold asserted
    id_stall = 1'b0;
    jmp_vld  = 1'b0;
    rst      = 1'b1;
    #1;
    chk("arst_vld",  {31'b0, ID_vld},  32'd0);
    chk("arst_hold", {31'b0, IF_hold}, 32'd0);
    chk("arst_pc",   ID_pc,            32'h0);
    chk("arst_inst", ID_inst,          NOP);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_vld0", {31'b0, ID_vld}, 32'd1);
    chk("post_pc0",  ID_pc,           32'h0);
    @(posedge clk);
    #1;
    chk("post_pc1",   ID_pc,            32'h4);
    chk("post_hold1", {31'b0, IF_hold}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
